// File: rtl/rst_seq.sv
// Reset sequencer: holds all domains in reset until the request has been quiet
// for HOLD_CYCLES, then releases domains one at a time, STAGE_GAP cycles apart.

module rst_seq_stage (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic set,
  output logic rst_no
);
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) rst_no <= 1'b0;
    else if (set)     rst_no <= 1'b1;
  end
endmodule

module rst_seq #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sys_rst_ni,
  input  logic                  ndmreset_i,
  output logic [NUM_STAGES-1:0] stage_rst_no,
  output logic                  rst_done_o,
  output logic                  ndmreset_ack_o
);
  localparam int                  IW       = 4;
  localparam logic [7:0]          HOLD_M1  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]          GAP_M1   = 8'(STAGE_GAP - 1);
  localparam logic [IW-1:0]       LAST_IDX = IW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ONE    = 1;

  typedef enum logic [1:0] {ASSERT, RELEASE, DONE} state_e;

  state_e          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic [7:0]      gap_q, gap_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cause_q, cause_d;
  logic            done_q, done_d;
  logic            ack_q, ack_d;
  logic [NUM_STAGES-1:0] stage_set;
  logic            stage_clr;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ASSERT;
      hold_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      cause_q <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      cause_q <= cause_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    cause_d   = cause_q;
    done_d    = done_q;
    ack_d     = 1'b0;
    stage_set = '0;
    stage_clr = 1'b0;
    if (!sys_rst_ni) begin
      // any request restarts from scratch; the last requesting cycle names the cause
      cause_d   = ndmreset_i;
      state_d   = ASSERT;
      stage_clr = 1'b1;
      hold_d    = '0;
      gap_d     = '0;
      idx_d     = '0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        ASSERT: begin
          if (hold_q >= HOLD_M1) begin
            stage_set[0] = 1'b1;
            hold_d       = '0;
            gap_d        = '0;
            idx_d        = IW'(1);
            if (NUM_STAGES == 1) begin
              state_d = DONE;
              done_d  = 1'b1;
              ack_d   = cause_q;
              cause_d = 1'b0;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            hold_d = sat_inc(hold_q);
          end
        end
        RELEASE: begin
          if (gap_q >= GAP_M1) begin
            stage_set = ONE << idx_q;
            gap_d     = '0;
            idx_d     = idx_q + IW'(1);
            if (idx_q >= LAST_IDX) begin
              state_d = DONE;
              done_d  = 1'b1;
              ack_d   = cause_q;
              cause_d = 1'b0;
            end
          end else begin
            gap_d = sat_inc(gap_q);
          end
        end
        DONE:    state_d = DONE;
        default: state_d = ASSERT;
      endcase
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    rst_seq_stage u_stage (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr    (stage_clr),
      .set    (stage_set[s]),
      .rst_no (stage_rst_no[s])
    );
  end

  assign rst_done_o     = done_q;
  assign ndmreset_ack_o = ack_q;
endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: default instance plus a NUM_STAGES=1/HOLD_CYCLES=1 instance.

module tb_rst_seq;
  logic clk = 1'b0;
  logic rst_i, sys, sys1, ndm;
  logic [2:0] st0;
  logic [0:0] st1;
  logic done0, ack0, done1, ack1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int ack_cnt = 0;

  typedef struct {
    int         cyc;
    string      tag;
    bit         which;
    logic [4:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rst_seq u_dut (
    .clk_i(clk), .rst_i(rst_i), .sys_rst_ni(sys), .ndmreset_i(ndm),
    .stage_rst_no(st0), .rst_done_o(done0), .ndmreset_ack_o(ack0)
  );

  rst_seq #(.NUM_STAGES(1), .HOLD_CYCLES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .sys_rst_ni(sys1), .ndmreset_i(ndm),
    .stage_rst_no(st1), .rst_done_o(done1), .ndmreset_ack_o(ack1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // expected {stage[2:0], done, ack} at cycle cyc+d
  task automatic expq(input int d, input string tag, input bit which, input logic [4:0] v);
    exp_t e;
    e.cyc = cyc + d; e.tag = tag; e.which = which; e.v = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (ack0) ack_cnt++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [4:0] obs;
      e = sb.pop_front();
      obs = e.which ? {2'b00, st1, done1, ack1} : {st0, done0, ack0};
      if (e.cyc != cyc) chk({e.tag, "_late"}, e.cyc, cyc);
      else              chk(e.tag, obs, e.v);
    end
  end

  initial begin
    rst_i = 1'b1; sys = 1'b1; sys1 = 1'b0; ndm = 1'b0;
    step(2);
    expq(0, "rst", 0, 5'b00000);
    expq(0, "rst1", 1, 5'b00000);
    step(1);
    rst_i = 1'b0;

    // T1: constant quiet request
    expq(15, "t1_h15", 0, 5'b00000);
    expq(16, "t1_s0",  0, 5'b00100);
    expq(23, "t1_23",  0, 5'b00100);
    expq(24, "t1_s1",  0, 5'b01100);
    expq(31, "t1_31",  0, 5'b01100);
    expq(32, "t1_done",0, 5'b11110);
    step(40);
    chk("t1_noack", ack_cnt, 0);

    // T2: one-cycle glitch at hold count 10
    sys = 1'b0; step(1);
    expq(0, "t2_clr", 0, 5'b00000);
    sys = 1'b1; step(10);
    sys = 1'b0; step(1);
    sys = 1'b1;
    expq(5,  "t2_nohold", 0, 5'b00000);
    expq(15, "t2_h15",    0, 5'b00000);
    expq(16, "t2_s0",     0, 5'b00100);
    expq(32, "t2_done",   0, 5'b11110);
    step(40);

    // T3: ndmreset-caused request for 3 cycles
    sys = 1'b0; ndm = 1'b1; step(1);
    expq(0, "t3_clr", 0, 5'b00000);
    step(2);
    sys = 1'b1; ndm = 1'b0;
    expq(16, "t3_s0",     0, 5'b00100);
    expq(31, "t3_pre",    0, 5'b01100);
    expq(32, "t3_ack",    0, 5'b11111);
    expq(33, "t3_ackend", 0, 5'b11110);
    step(40);
    chk("t3_ackcnt", ack_cnt, 1);

    // T4: request drops mid-release
    sys = 1'b0; step(1);
    sys = 1'b1;
    expq(26, "t4_011", 0, 5'b01100);
    step(26);
    sys = 1'b0; step(1);
    expq(0, "t4_clr", 0, 5'b00000);
    sys = 1'b1;
    expq(15, "t4_h15",  0, 5'b00000);
    expq(16, "t4_s0",   0, 5'b00100);
    expq(32, "t4_done", 0, 5'b11110);
    step(40);
    chk("t4_ackcnt", ack_cnt, 1);

    // T5: rst_i pulse mid-release also drops an ndmreset cause
    sys = 1'b0; ndm = 1'b1; step(1);
    sys = 1'b1; ndm = 1'b0;
    expq(26, "t5_011", 0, 5'b01100);
    step(26);
    rst_i = 1'b1; step(1);
    expq(0, "t5_rst", 0, 5'b00000);
    rst_i = 1'b0;
    expq(15, "t5_h15",  0, 5'b00000);
    expq(16, "t5_s0",   0, 5'b00100);
    expq(24, "t5_s1",   0, 5'b01100);
    expq(32, "t5_done", 0, 5'b11110);
    step(40);
    chk("t5_ackcnt", ack_cnt, 1);

    // T6: single stage, hold of one
    sys1 = 1'b1;
    expq(0, "t6_pre", 1, 5'b00000);
    expq(1, "t6_rel", 1, 5'b00110);
    step(3);
    sys1 = 1'b0;
    expq(1, "t6_clr", 1, 5'b00000);
    step(2);
    ndm = 1'b1; step(1);
    sys1 = 1'b1; ndm = 1'b0;
    expq(0, "t6_req",    1, 5'b00000);
    expq(1, "t6_ack",    1, 5'b00111);
    expq(2, "t6_ackend", 1, 5'b00110);
    expq(2, "t6_main",   0, 5'b11110);
    step(4);
    chk("t6_ackcnt", ack_cnt, 1);

    step(2);
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, meaning number of sequenced reset domains; legal range 1..8.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, meaning minimum consecutive deasserted-request cycles before the first release; legal range 1..255.
REQ-003 SHALL have parameter STAGE_GAP, default 8, meaning cycles between consecutive stage releases; legal range 1..255.
REQ-004 SHALL have port clk_i  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port sys_rst_ni  input  1  combined system reset request from the reset manager; low = reset requested.
REQ-007 SHALL have port ndmreset_i  input  1  debug non-debug-module reset request, used only for cause tracking.
REQ-008 SHALL have port stage_rst_no  output  NUM_STAGES  per-domain active-low resets; bit 0 released first.
REQ-009 SHALL have port rst_done_o  output  1  high while every stage is released.
REQ-010 SHALL have port ndmreset_ack_o  output  1  one-cycle pulse at completion of an ndmreset-caused sequence.

Function
REQ-011 SHALL drive all outputs from flops; no combinational path from any input to any output.
REQ-012 SHALL implement FSM states ASSERT, RELEASE, DONE.
REQ-013 ASSERT: all stage_rst_no bits 0, rst_done_o 0; the hold counter increments on each cycle with sys_rst_ni=1 and clears to 0 on any cycle with sys_rst_ni=0.
REQ-014 ASSERT->RELEASE on the edge ending the HOLD_CYCLES-th consecutive sys_rst_ni=1 cycle; stage_rst_no[0] becomes 1 on that same edge.
REQ-015 RELEASE: a gap counter counts cycles; every STAGE_GAP cycles the next stage bit becomes 1, in ascending index order, one bit per step.
REQ-016 SHALL enter DONE, with rst_done_o=1, on the same edge that releases stage NUM_STAGES-1; if NUM_STAGES=1, go ASSERT->DONE directly at the REQ-014 edge.
REQ-017 DONE: all stage bits 1; hold until a reset request occurs.
REQ-018 sys_rst_ni=0 in RELEASE or DONE SHALL cause, on the next edge: state ASSERT, all stage bits 0, rst_done_o 0, both counters 0.
REQ-019 SHALL keep a cause flag that is set on any edge where sys_rst_ni=0 and ndmreset_i=1, and cleared on any edge where sys_rst_ni=0 and ndmreset_i=0; the last requesting cycle determines the cause.
REQ-020 ndmreset_ack_o SHALL pulse high for exactly one cycle, coincident with the first rst_done_o=1 cycle, iff the cause flag is set; the flag clears on that edge.
REQ-021 Counters SHALL be 8 bits wide; they saturate and never wrap.
REQ-022 Release timing SHALL NOT depend on ndmreset_i.

Reset
REQ-023 rst_i=1 SHALL force, on the next edge: state ASSERT, stage_rst_no=0, rst_done_o=0, ndmreset_ack_o=0, both counters 0, cause flag 0.
REQ-024 rst_i SHALL take priority over all other inputs, including mid-sequence.
REQ-025 rst_i=1 while stage releases are in progress SHALL abort the sequence; a fresh full HOLD_CYCLES count is required after rst_i falls.

Verification
REQ-026 Test 1 (defaults): rst_i low, sys_rst_ni=1 constant -> stage_rst_no = 001 after 16 cycles, 011 after 24, 111 after 32; rst_done_o rises at cycle 32; no ack pulse.
REQ-027 Test 2 (glitch): sys_rst_ni low for 1 cycle at hold count 10 -> count restarts; stage_rst_no[0] rises 16 cycles after sys_rst_ni returns high.
REQ-028 Test 3 (ndmreset): in DONE, sys_rst_ni=0 and ndmreset_i=1 for 3 cycles -> stages 000 one cycle later; after the full sequence, ndmreset_ack_o is high for 1 cycle coincident with rst_done_o rising.
REQ-029 Test 4 (mid-sequence): sys_rst_ni drops while stage_rst_no=011 -> next cycle 000, rst_done_o 0; the sequence restarts from the hold phase.
REQ-030 Test 5 (rst_i): rst_i pulse at stage_rst_no=011 with sys_rst_ni=1 -> next cycle all outputs 0; release of stage 0 occurs 16 cycles after rst_i falls.
REQ-031 Test 6 (edge parameters): NUM_STAGES=1, HOLD_CYCLES=1 -> stage_rst_no[0] and rst_done_o rise together 1 cycle after the first sys_rst_ni=1 cycle.
